// File: rtl/mod_addsub_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mod_addsub_pipe_pkg
// Shared constants for the modular add/sub pipeline: the Kyber and Dilithium
// moduli with their coefficient widths, and the encoding of the op select.
// ---------------------------------------------------------------------------
package mod_addsub_pipe_pkg;

  // Kyber: q = 3329, 12-bit coefficients
  localparam int unsigned KYBER_Q     = 3329;
  localparam int unsigned KYBER_W     = 12;

  // Dilithium: q = 8380417, 23-bit coefficients
  localparam int unsigned DILITHIUM_Q = 8380417;
  localparam int unsigned DILITHIUM_W = 23;

  // Operation select, shared by every lane of a transaction
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : mod_addsub_pipe_pkg

// File: rtl/mod_addsub_lane.sv
// ---------------------------------------------------------------------------
// mod_addsub_lane
// Purely combinational single-lane modular add/sub. The lane holds both
// halves of the pipelined computation; the enclosing pipeline registers the
// raw result between them.
//
//   a, b      : operands entering the first stage
//   op        : OP_ADD / OP_SUB for the first-stage operands
//   raw_c     : WIDTH+1 bit raw sum, or two's-complement difference whose
//               top bit is the borrow
//   oor_c     : either operand is outside [0, Q-1]
//   raw_in    : registered raw value entering the correction stage
//   raw_op    : registered op matching raw_in
//   res_c     : corrected result, in [0, Q-1] for in-range operands
// ---------------------------------------------------------------------------
module mod_addsub_lane
  import mod_addsub_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = KYBER_W,
  parameter int unsigned Q     = KYBER_Q
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH:0]   raw_c,
  output logic             oor_c,
  input  logic [WIDTH:0]   raw_in,
  input  logic             raw_op,
  output logic [WIDTH-1:0] res_c
);

  localparam logic [WIDTH:0]   Q_EXT = (WIDTH + 1)'(Q);
  localparam logic [WIDTH-1:0] Q_W   = WIDTH'(Q);

  // Raw result: a zero-extended add, or a subtract whose wrap sets the top bit
  always_comb begin
    raw_c = '0;
    if (op == OP_SUB) begin
      raw_c = {1'b0, a} - {1'b0, b};
    end else begin
      raw_c = {1'b0, a} + {1'b0, b};
    end
  end

  // Operand range check feeding the sticky error flag
  assign oor_c = (a >= Q_W) || (b >= Q_W);

  // Single conditional correction back into [0, Q-1]
  always_comb begin
    res_c = raw_in[WIDTH-1:0];
    if (raw_op == OP_SUB) begin
      // Borrow means the difference went negative; adding Q modulo 2^WIDTH
      // lands it in range without needing the extra bit.
      if (raw_in[WIDTH]) begin
        res_c = raw_in[WIDTH-1:0] + Q_W;
      end
    end else if (raw_in >= Q_EXT) begin
      res_c = WIDTH'(raw_in - Q_EXT);
    end
  end

endmodule : mod_addsub_lane

// File: rtl/mod_addsub_pipe.sv
// ---------------------------------------------------------------------------
// mod_addsub_pipe
// Two-stage, multi-lane modular adder/subtractor with valid/ready on both
// sides. Stage 1 registers the raw WIDTH+1 bit per-lane result; stage 2
// registers the corrected result. Sustains one transaction per clock while
// out_ready is high.
//
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : input transaction valid
//   in_ready   : input accepted this cycle when high (depends only on state
//                and out_ready, never on in_valid)
//   in_op      : OP_ADD / OP_SUB for all lanes
//   in_tag     : sideband tag returned unchanged with the result
//   in_a, in_b : LANES packed operands, lane i at [i*WIDTH +: WIDTH]
//   out_valid  : result valid, held with its data until out_ready
//   out_ready  : downstream accepts the result this cycle
//   out_data   : LANES packed results, same packing as the inputs
//   out_tag    : tag of the transaction in out_data
//   range_err  : sticky; some accepted operand lane was >= Q
// ---------------------------------------------------------------------------
module mod_addsub_pipe
  import mod_addsub_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = KYBER_W,
  parameter int unsigned Q     = KYBER_Q,
  parameter int unsigned LANES = 1,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_op,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   range_err
);

  localparam int unsigned RAW_W = WIDTH + 1;

  // Stage-1 registers
  logic                   s1_valid;
  logic                   s1_op;
  logic [TAG_W-1:0]       s1_tag;
  logic [LANES*RAW_W-1:0] s1_raw;

  // Lane outputs
  logic [LANES*RAW_W-1:0] raw_c;
  logic [LANES*WIDTH-1:0] res_c;
  logic [LANES-1:0]       oor_c;

  // Flow control
  logic s2_en;
  logic s1_en;
  logic accept;

  // A stage may load when it is empty or its contents move on this cycle
  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;
  assign accept   = in_valid && s1_en;

  // One lane instance per coefficient; each covers both stages of its lane
  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    mod_addsub_lane #(
      .WIDTH (WIDTH),
      .Q     (Q)
    ) u_lane (
      .a      (in_a[i*WIDTH +: WIDTH]),
      .b      (in_b[i*WIDTH +: WIDTH]),
      .op     (in_op),
      .raw_c  (raw_c[i*RAW_W +: RAW_W]),
      .oor_c  (oor_c[i]),
      .raw_in (s1_raw[i*RAW_W +: RAW_W]),
      .raw_op (s1_op),
      .res_c  (res_c[i*WIDTH +: WIDTH])
    );
  end

  // Stage 1: capture raw results, op and tag on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_tag   <= '0;
      s1_raw   <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= in_op;
        s1_tag <= in_tag;
        s1_raw <= raw_c;
      end
    end
  end

  // Stage 2: corrected result; holds while stalled, empties on a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res_c;
        out_tag  <= s1_tag;
      end
    end
  end

  // Sticky operand range error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_err <= 1'b0;
    end else if (accept && (|oor_c)) begin
      range_err <= 1'b1;
    end
  end

endmodule : mod_addsub_pipe
